// File: rtl/mips_pipeline_sequencer_pkg.sv
// Shared encodings for the MIPS pipeline sequencer and its hazard unit.
package mips_pipeline_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_pipeline_sequencer_hazard_detect.sv
// Load-use hazard comparator: an EX-stage lw whose destination feeds the ID-stage instruction.
module mips_hazard_detect
    import mips_pipeline_sequencer_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hazard
);

    // Register zero never carries a real dependency.
    always_comb begin
        hazard = ex_mem_read && (ex_rt != REG_ZERO) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/mips_pipeline_sequencer.sv
// Pipeline sequencer: memory-wait FSM with timeout, load-use stalls, flushes and a stall counter.
module mips_pipeline_sequencer
    import mips_pipeline_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             flush_req,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    state_t     state;
    state_t     next_state;
    state_t     eff_state;
    logic [7:0] wait_cnt;
    logic [7:0] next_wait;
    logic       mem_stall;
    logic       hazard;

    mips_hazard_detect u_hazard (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_mem_read(ex_mem_read),
        .ex_rt      (ex_rt),
        .hazard     (hazard)
    );

    // While rst is asserted the outputs decode as RUN, whatever the stored state.
    always_comb begin
        eff_state = rst ? RUN : state;
    end

    // Next-state and output decode; priority ERR > memory stall > load-use > flush > normal.
    always_comb begin
        next_state   = state;
        next_wait    = wait_cnt;
        mem_stall    = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        dmem_req     = 1'b0;
        mem_err      = 1'b0;

        case (eff_state)
            RUN: begin
                dmem_req = mem_access;
                if (mem_access && !dmem_ready) begin
                    mem_stall  = 1'b1;
                    next_state = MEM_WAIT;
                    next_wait  = 8'd1;
                end
            end
            MEM_WAIT: begin
                dmem_req = mem_access;
                if (dmem_ready) begin
                    next_state = RUN;
                    next_wait  = '0;
                end else begin
                    // Timeout is judged on the incremented count, so ERR follows
                    // exactly MEM_TIMEOUT stalled cycles including the RUN entry cycle.
                    mem_stall = 1'b1;
                    next_wait = wait_cnt + 8'd1;
                    if (next_wait == 8'(MEM_TIMEOUT)) begin
                        next_state = ERR;
                    end
                end
            end
            ERR: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
                mem_err     = 1'b1;
            end
            default: begin
                next_state = RUN;
                next_wait  = '0;
            end
        endcase

        if (mem_stall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (eff_state == RUN && hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (eff_state == RUN && flush_req) begin
            ifid_flush = 1'b1;
        end
    end

    // State, wait counter and saturating front-end stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait;
            if (!pc_write && state != ERR && stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_pipeline_sequencer.sv
// Scoreboard bench for mips_pipeline_sequencer: expectations queued with stimulus, popped at the negedge.
module tb_mips_pipeline_sequencer;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 16;

    // Output vector: {pc_write, ifid_write, idex_write, exmem_write,
    //                 ifid_flush, idex_bubble, memwb_bubble, dmem_req, mem_err}
    localparam logic [8:0] V_NORM = 9'b1111_000_00;
    localparam logic [8:0] V_MEM  = 9'b0000_001_00;
    localparam logic [8:0] V_LU   = 9'b0011_010_00;
    localparam logic [8:0] V_FL   = 9'b1111_100_00;
    localparam logic [8:0] V_ERR  = 9'b0000_000_01;
    localparam logic [8:0] DREQ   = 9'b0000_000_10;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             ex_mem_read, flush_req, mem_access, dmem_ready;
    logic             pc_write, ifid_write, idex_write, exmem_write;
    logic             ifid_flush, idex_bubble, memwb_bubble, dmem_req, mem_err;
    logic [CNT_W-1:0] stall_count;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       emr;
        logic [4:0] ert;
        logic       fl;
        logic       ma;
        logic       rdy;
    } stim_t;

    typedef struct {
        logic [8:0]       vec;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               passed = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    mips_pipeline_sequencer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .flush_req   (flush_req),
        .mem_access  (mem_access),
        .dmem_ready  (dmem_ready),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .idex_write  (idex_write),
        .exmem_write (exmem_write),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .memwb_bubble(memwb_bubble),
        .dmem_req    (dmem_req),
        .mem_err     (mem_err),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic emr, input logic [4:0] ert, input logic fl,
                                 input logic ma, input logic rdy);
        stim_t s;
        s.rst = r; s.rs = rs; s.rt = rt; s.emr = emr; s.ert = ert; s.fl = fl; s.ma = ma; s.rdy = rdy;
        return s;
    endfunction

    function automatic logic [8:0] observed();
        return {pc_write, ifid_write, idex_write, exmem_write,
                ifid_flush, idex_bubble, memwb_bubble, dmem_req, mem_err};
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; id_rs = s.rs; id_rt = s.rt; ex_mem_read = s.emr;
        ex_rt = s.ert; flush_req = s.fl; mem_access = s.ma; dmem_ready = s.rdy;
    endtask

    // Queue an expectation for one cycle and advance the reference stall counter past its edge.
    task automatic expect_cycle(input logic [8:0] v, input logic r, input string name);
        sb.push_back('{vec: v, cnt: exp_cnt, name: name});
        if (r) exp_cnt = '0;
        else if (!v[8] && !v[0] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  e;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        exp_cnt = '0;
        st.push_back(mk(1, 5, 0, 1, 5, 0, 0, 0)); expect_cycle(V_LU, 1, "reset_decodes_run");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); expect_cycle(V_NORM, 0, "reset_idle");
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e.vec) $display("FAIL %s outputs=%b required=%b", e.name, observed(), e.vec);
            else passed++;
            checks++;
            if (stall_count !== e.cnt) $display("FAIL %s stall_count=%0d required=%0d", e.name, stall_count, e.cnt);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(0, 5, 0, 1, 5, 0, 0, 0));  expect_cycle(V_LU, 0, "lu_rs");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));  expect_cycle(V_NORM, 0, "lu_after");
        st.push_back(mk(0, 3, 9, 1, 9, 0, 0, 0));  expect_cycle(V_LU, 0, "lu_rt");
        st.push_back(mk(0, 9, 3, 1, 4, 0, 0, 0));  expect_cycle(V_NORM, 0, "lu_nomatch");
        st.push_back(mk(0, 5, 5, 0, 5, 0, 0, 0));  expect_cycle(V_NORM, 0, "lu_not_load");
        st.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));  expect_cycle(V_NORM, 0, "lu_reg_zero");
        st.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0));  expect_cycle(V_FL, 0, "lu_reg_zero_flush");
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e.vec) $display("FAIL %s outputs=%b required=%b", e.name, observed(), e.vec);
            else passed++;
            checks++;
            if (stall_count !== e.cnt) $display("FAIL %s stall_count=%0d required=%0d", e.name, stall_count, e.cnt);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0)); expect_cycle(V_NORM, 1, "mw_reset");
        for (int i = 0; i < 3; i++) begin
            st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); expect_cycle(V_MEM | DREQ, 0, "mw_stall");
        end
        st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1)); expect_cycle(V_NORM | DREQ, 0, "mw_ready");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); expect_cycle(V_NORM, 0, "mw_back_in_run");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1)); expect_cycle(V_NORM | DREQ, 0, "mw_ready_first");
        st.push_back(mk(0, 5, 0, 1, 5, 1, 1, 0)); expect_cycle(V_MEM | DREQ, 0, "mw_beats_lu_flush");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1)); expect_cycle(V_NORM | DREQ, 0, "mw_release");
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e.vec) $display("FAIL %s outputs=%b required=%b", e.name, observed(), e.vec);
            else passed++;
            checks++;
            if (stall_count !== e.cnt) $display("FAIL %s stall_count=%0d required=%0d", e.name, stall_count, e.cnt);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(0, 5, 0, 1, 5, 1, 0, 0)); expect_cycle(V_LU, 0, "fl_lu_wins");
        st.push_back(mk(0, 5, 0, 0, 0, 1, 0, 0)); expect_cycle(V_FL, 0, "fl_alone");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); expect_cycle(V_NORM, 0, "fl_idle");
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e.vec) $display("FAIL %s outputs=%b required=%b", e.name, observed(), e.vec);
            else passed++;
            checks++;
            if (stall_count !== e.cnt) $display("FAIL %s stall_count=%0d required=%0d", e.name, stall_count, e.cnt);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout_ready_wins();
        stim_t st[$];
        exp_t  e;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); expect_cycle(V_MEM | DREQ, 0, "trw_stall");
        end
        st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1)); expect_cycle(V_NORM | DREQ, 0, "trw_ready_on_last");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); expect_cycle(V_NORM, 0, "trw_run");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); expect_cycle(V_MEM | DREQ, 0, "trw_rst_mid_wait_a");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); expect_cycle(V_MEM | DREQ, 0, "trw_rst_mid_wait_b");
        st.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0)); expect_cycle(V_MEM | DREQ, 1, "trw_rst_decode");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); expect_cycle(V_NORM, 0, "trw_after_rst");
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e.vec) $display("FAIL %s outputs=%b required=%b", e.name, observed(), e.vec);
            else passed++;
            checks++;
            if (stall_count !== e.cnt) $display("FAIL %s stall_count=%0d required=%0d", e.name, stall_count, e.cnt);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t st[$];
        exp_t  e;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); expect_cycle(V_MEM | DREQ, 0, "to_stall");
        end
        st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); expect_cycle(V_ERR, 0, "to_err");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1)); expect_cycle(V_ERR, 0, "to_err_sticky_ready");
        st.push_back(mk(0, 5, 0, 1, 5, 1, 0, 0)); expect_cycle(V_ERR, 0, "to_err_sticky_lu");
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0)); expect_cycle(V_NORM, 1, "to_rst_decode");
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); expect_cycle(V_NORM, 0, "to_after_rst");
        foreach (st[i]) begin
            apply(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e.vec) $display("FAIL %s outputs=%b required=%b", e.name, observed(), e.vec);
            else passed++;
            checks++;
            if (stall_count !== e.cnt) $display("FAIL %s stall_count=%0d required=%0d", e.name, stall_count, e.cnt);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        apply(mk(0, 5, 0, 1, 5, 0, 0, 0));
        repeat (70000) @(posedge clk);
        #1;
        exp_cnt = '1;
        for (int i = 0; i < 2; i++) begin
            expect_cycle(V_LU, 0, "sat_hold");
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e.vec) $display("FAIL %s outputs=%b required=%b", e.name, observed(), e.vec);
            else passed++;
            checks++;
            if (stall_count !== e.cnt) $display("FAIL %s stall_count=%0d required=%0d", e.name, stall_count, e.cnt);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_load_use();
        test_mem_wait();
        test_flush();
        test_timeout_ready_wins();
        test_timeout();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
